// File: rtl/relay_shift_driver.sv
// Serialises a parallel relay word into a 74HC595-style chain.
// Bit timing comes from a sampled divided clock; everything else runs on clk_in.
module relay_shift_driver #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             clk_div,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             busy,
    output logic             done,
    output logic             sr_ser,
    output logic             sr_sck,
    output logic             sr_rck,
    output logic             sr_oe_n
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_LATCH,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_div_meta;
    logic             r_div_sync;
    logic             r_div_prev;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_ser;
    logic             r_sck;
    logic             r_rck;
    logic             r_oe_n;

    logic             w_tick;
    logic             w_cur_bit;
    logic [WIDTH-1:0] w_shift_next;

    assign w_tick = r_div_sync & ~r_div_prev;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_cur_bit    = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign w_cur_bit    = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_div_meta <= 1'b0;
            r_div_sync <= 1'b0;
            r_div_prev <= 1'b0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ser      <= 1'b0;
            r_sck      <= 1'b0;
            r_rck      <= 1'b0;
            r_oe_n     <= 1'b1;
        end else begin
            r_div_meta <= clk_div;
            r_div_sync <= r_div_meta;
            r_div_prev <= r_div_sync;
            r_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_sck <= 1'b0;
                    r_rck <= 1'b0;
                    if (data_valid && r_ready) begin
                        r_shift <= data_in;
                        r_cnt   <= CW'(WIDTH);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: if (w_tick) begin
                    r_ser   <= w_cur_bit;
                    r_sck   <= 1'b0;
                    r_state <= S_HIGH;
                end
                S_HIGH: if (w_tick) begin
                    r_sck   <= 1'b1;
                    r_state <= S_LOW;
                end
                S_LOW: if (w_tick) begin
                    r_sck   <= 1'b0;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt - CW'(1);
                    // Counter reaches zero on this tick when it currently holds one.
                    r_state <= (r_cnt == CW'(1)) ? S_LATCH : S_SETUP;
                end
                S_LATCH: if (w_tick) begin
                    r_rck   <= 1'b1;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: if (w_tick) begin
                    r_rck   <= 1'b0;
                    r_oe_n  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_ready = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sr_ser     = r_ser;
    assign sr_sck     = r_sck;
    assign sr_rck     = r_rck;
    assign sr_oe_n    = r_oe_n;
endmodule
